// File: rtl/uart_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_defs (package)
// Description : Shared UART definitions for the TX path and the future RX path:
//               FSM state encodings, oversampling factor and the clock divider
//               derivation for the oversample tick.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_defs;

    // Oversample ticks per bit period
    localparam int OVERSAMPLE = 16;

    // Frame FSM state encodings
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // Clock cycles per oversample tick, truncated
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return clk_freq / (baud_rate * OVERSAMPLE);
    endfunction

endpackage : uart_defs
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen
// Description : Oversample tick generator. Emits a one-cycle o_tick every DIV
//               clock cycles. i_clear zeroes the counter so the first tick
//               after a clear lands exactly DIV cycles later.
// Ports       : i_clock   - system clock
//               i_reset_n - asynchronous active-low reset
//               i_clear   - synchronous counter clear
//               o_tick    - one-cycle tick
// Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
    parameter int DIV = 1
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV - 1);

    generate
        if (DIV < 1) begin : g_div_check
            $error("baud_tick_gen: DIV must be at least 1");
        end
    endgenerate

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear || (r_count == C_LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Tick on the last count, so a clear at cycle N yields a tick at N+DIV
    assign o_tick = (r_count == C_LAST);

endmodule : baud_tick_gen
`default_nettype wire

// File: rtl/alu_result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_uart_tx
// Description : UART 8N1-style transmitter for the ALU result. On an accepted
//               send request the LEN_DATO-bit result is captured and shifted
//               out LSB first, 16 oversample ticks per bit.
// Ports       : i_clock     - system clock
//               i_reset_n   - asynchronous active-low reset
//               i_resultado - ALU result, captured on acceptance
//               i_send      - send request, honoured only while idle
//               o_tx        - registered serial line, idle high
//               o_busy      - frame in progress
//               o_done      - one-cycle pulse when the stop bit completes
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_uart_tx
    import uart_defs::*;
#(
    parameter int LEN_DATO  = 8,
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic [LEN_DATO-1:0] i_resultado,
    input  logic                i_send,
    output logic                o_tx,
    output logic                o_busy,
    output logic                o_done
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int BIT_W = (LEN_DATO > 1) ? $clog2(LEN_DATO) : 1;
    localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(LEN_DATO - 1);
    localparam logic [3:0]       C_LAST_OS  = 4'(OVERSAMPLE - 1);

    generate
        if (DIV < 1) begin : g_div_check
            $error("alu_result_uart_tx: CLK_FREQ too low for BAUD_RATE*16");
        end
    endgenerate

    logic [1:0]          r_state;
    logic [3:0]          r_os_cnt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [LEN_DATO-1:0] r_shift;
    logic                r_tx;
    logic                r_done;

    logic                w_tick;
    logic                w_clear;
    logic                w_last_os;
    logic [LEN_DATO-1:0] w_shift_next;

    // Holding the generator in clear while idle restarts the tick phase on
    // acceptance, so frame timing never depends on earlier tick history.
    assign w_clear      = (r_state == IDLE);
    assign w_last_os    = w_tick && (r_os_cnt == C_LAST_OS);
    assign w_shift_next = r_shift >> 1;

    baud_tick_gen #(
        .DIV (DIV)
    ) u_baud_tick_gen (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (w_clear),
        .o_tick    (w_tick)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_tick) begin
                r_os_cnt <= w_last_os ? 4'd0 : r_os_cnt + 4'd1;
            end
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (i_send) begin
                        r_shift   <= i_resultado;
                        r_os_cnt  <= '0;
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b0;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_last_os) begin
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_last_os) begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == C_LAST_BIT) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            // Next line level is the bit about to reach position 0
                            r_tx      <= w_shift_next[0];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (w_last_os) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_tx   = r_tx;
    assign o_busy = (r_state != IDLE);
    assign o_done = r_done;

endmodule : alu_result_uart_tx
`default_nettype wire

// File: tb/tb_alu_result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_uart_tx
// Description : Directed, table-driven bench for alu_result_uart_tx with
//               CLK_FREQ=1600, BAUD_RATE=100 (DIV=1, 16 cycles per bit).
//               Cycle c of a frame is the c-th clock after the accepting edge;
//               outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_uart_tx;

    localparam int LEN_DATO  = 8;
    localparam int CLK_FREQ  = 1600;
    localparam int BAUD_RATE = 100;
    localparam int BIT       = 16;
    localparam int FRAME     = (LEN_DATO + 2) * BIT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       send;
    logic [7:0] res;
    logic       tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_result_uart_tx #(
        .LEN_DATO  (LEN_DATO),
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_resultado (res),
        .i_send      (send),
        .o_tx        (tx),
        .o_busy      (busy),
        .o_done      (done)
    );

    // Expected line levels: bit i of exp is the level during bit slot i
    // (slot 0 = start, slots 1..8 = data LSB first, slot 9 = stop).
    typedef struct {
        logic [7:0] data;
        logic [9:0] exp;
        int         chg_at;
        logic [7:0] chg_data;
        int         pulse_at;
        logic [7:0] pulse_data;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int c, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %b want %b", name, c, got, want);
        end
    endtask

    task automatic check_idle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({name, "_tx"}, i, tx, 1'b1);
            chk({name, "_busy"}, i, busy, 1'b0);
            chk({name, "_done"}, i, done, 1'b0);
        end
    endtask

    // Drive a one-cycle (or held) request; returns at the falling edge of cycle 1
    task automatic start_frame(input logic [7:0] d, input logic hold);
        res  = d;
        send = 1'b1;
        @(negedge clk);
        if (!hold) send = 1'b0;
    endtask

    // Check cycles 1..FRAME, then the done cycle; ends on the done cycle's falling edge
    task automatic check_frame(input logic [9:0] exp, input int chg_at, input logic [7:0] chg_data,
                               input int pulse_at, input logic [7:0] pulse_data, input int release_at);
        for (int c = 1; c <= FRAME; c++) begin
            chk("frame_tx", c, tx, exp[(c-1)/BIT]);
            chk("frame_busy", c, busy, 1'b1);
            chk("frame_done", c, done, 1'b0);
            if (c == chg_at) res = chg_data;
            if (c == pulse_at) begin
                send = 1'b1;
                res  = pulse_data;
            end else if (c == pulse_at + 1) begin
                send = 1'b0;
            end
            if (c == release_at) send = 1'b0;
            @(negedge clk);
        end
        chk("done_pulse", FRAME + 1, done, 1'b1);
        chk("done_busy", FRAME + 1, busy, 1'b0);
        chk("done_tx", FRAME + 1, tx, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{data: 8'hA5, exp: 10'b1101001010, chg_at: -1, chg_data: 8'h00, pulse_at: 40, pulse_data: 8'h3C};
        vecs[1] = '{data: 8'hF6, exp: 10'b1111101100, chg_at: 50, chg_data: 8'h00, pulse_at: -1, pulse_data: 8'h00};
        vecs[2] = '{data: 8'hFF, exp: 10'b1111111110, chg_at: -1, chg_data: 8'h00, pulse_at: -1, pulse_data: 8'h00};
        vecs[3] = '{data: 8'h00, exp: 10'b1000000000, chg_at: 20, chg_data: 8'hFF, pulse_at: 100, pulse_data: 8'h81};

        // Reset
        rst_n = 1'b0;
        send  = 1'b0;
        res   = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", 0, tx, 1'b1);
        chk("rst_busy", 0, busy, 1'b0);
        chk("rst_done", 0, done, 1'b0);
        rst_n = 1'b1;
        check_idle("post_rst", 500);

        // Table-driven frames
        for (int v = 0; v < 4; v++) begin
            start_frame(vecs[v].data, 1'b0);
            check_frame(vecs[v].exp, vecs[v].chg_at, vecs[v].chg_data,
                        vecs[v].pulse_at, vecs[v].pulse_data, -1);
            check_idle("after_frame", 40);
        end

        // Back-to-back: request held, second capture in the done cycle
        start_frame(8'h01, 1'b1);
        check_frame(10'b1000000010, -1, 8'h00, -1, 8'h00, -1);
        @(negedge clk);
        check_frame(10'b1000000010, -1, 8'h00, -1, 8'h00, FRAME);
        check_idle("after_b2b", 40);

        // Reset mid-frame at cycle 70, then a fresh frame
        start_frame(8'hA5, 1'b0);
        repeat (69) @(negedge clk);
        chk("pre_rst_busy", 70, busy, 1'b1);
        chk("pre_rst_tx", 70, tx, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", 70, tx, 1'b1);
        chk("mid_rst_busy", 70, busy, 1'b0);
        chk("mid_rst_done", 70, done, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("in_rst_done", 0, done, 1'b0);
            chk("in_rst_tx", 0, tx, 1'b1);
        end
        rst_n = 1'b1;
        check_idle("after_rst", 200);
        start_frame(8'h5A, 1'b0);
        check_frame(10'b1010110100, -1, 8'h00, -1, 8'h00, -1);
        check_idle("final", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_result_uart_tx
`default_nettype wire
